pipe_mem_arbiter: RTL
=====================

Name: pipe_mem_arbiter

Overview:
- Sits directly downstream of the pipelined CPU datapath.
- Merges its instruction-fetch port and data (MEM-stage) port onto one shared physical-memory/L2 port.
- Serializes accesses with a small FSM and holds completed read data and responses stable until the pipeline advances.
- Lets IF and MEM stalls resolve in any order.

Parameters:
- ADDR_W, 16, address width of all ports.
- DATA_W, 16, data width of all ports.
- DATA_FIRST, 1, fixed priority when both ports request in IDLE: 1 = data port wins, 0 = instruction port wins.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- advance  in  1  pipeline advance strobe from datapath; consumes both held responses
- instruction_request  in  1  fetch request, held high until consumed
- instruction_address  in  ADDR_W  fetch address
- instr  out  DATA_W  fetched word
- instruction_response  out  1  fetched word valid for current instruction_address
- data_request  in  1  data access request
- mem_address  in  ADDR_W  data address
- write_enable  in  1  1 = store, 0 = load
- write_data  in  DATA_W  store data
- mem_byte_enable  in  2  store byte lanes
- mem_rdata  out  DATA_W  load data
- data_response  out  1  data access complete
- pmem_address  out  ADDR_W  shared-port address
- pmem_wdata  out  DATA_W  shared-port write data
- pmem_byte_enable  out  2  shared-port byte lanes (2'b11 on reads)
- pmem_read  out  1  shared-port read strobe
- pmem_write  out  1  shared-port write strobe
- pmem_rdata  in  DATA_W  shared-port read data
- pmem_resp  in  1  shared-port completion, single-cycle pulse

Behaviour:
- Reset (async, rst_n low): state = IDLE; all outputs 0; ivalid = 0, dvalid = 0, iaddr = 0. Reset mid-transaction drops pmem_read/pmem_write immediately; the in-flight access is abandoned.
- FSM states: IDLE, IFETCH, DACCESS.
- IDLE, candidates:
  - data candidate = data_request & !dvalid.
  - instruction candidate = instruction_request & !instruction_response.
  - Both present: DATA_FIRST selects the winner.
  - The winner's address/wdata/byte_enable/write_enable are registered onto the pmem_* outputs at the transition edge.
  - pmem_read or pmem_write is asserted in the first cycle of IFETCH/DACCESS.
- IFETCH: pmem_read = 1 and pmem_* stable until pmem_resp. On pmem_resp: instr <= pmem_rdata, iaddr <= registered fetch address, ivalid <= 1, go to IDLE.
- DACCESS: pmem_read = !write_enable, pmem_write = write_enable (as latched), stable until pmem_resp. On pmem_resp: mem_rdata <= pmem_rdata (loads only; stores leave mem_rdata unchanged), dvalid <= 1, go to IDLE.
- pmem_resp outside IFETCH/DACCESS is ignored.
- Outputs:
  - instruction_response = ivalid & (iaddr == instruction_address). Combinational compare against a registered flag.
  - data_response = dvalid (registered).
- Hold/clear rules:
  - advance = 1 clears ivalid and dvalid on the next edge. Responses stay high until then, so the datapath's advance = instruction_response & readymemwb can close.
  - ivalid with address mismatch (redirect/flush changed PC): ivalid cleared next edge and a new fetch is eligible. A fetch already in flight always completes; its result is then compared and discarded on mismatch.
  - data_request low while dvalid = 1: dvalid cleared.
  - pmem_resp and advance in the same cycle: the completing access sets its valid flag; advance clears only the previously held flag.
- Latency: request seen in IDLE at cycle N → pmem strobe at N+1 → response at (pmem_resp cycle)+1. Minimum is 2 cycles with a zero-wait memory.
- No combinational path from pmem_resp to instruction_response/data_response.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: DATA_FIRST is ignored. A 1-bit last_grant register (reset 0 = instruction) gives the contested grant to the port not granted last.
- Undefined: fixed priority per DATA_FIRST; no last_grant register.

Test Plan:
- Instruction-only fetch, addr 0x0040, pmem_resp 3 cycles after pmem_read with 0x1234 → instr = 0x1234, instruction_response high and held until advance pulse, then low.
- Both ports request in the same cycle (fetch 0x0010, load 0x2000), DATA_FIRST = 1 → pmem_address 0x2000 first, then 0x0010. With ARB_ROUND_ROBIN_EN repeated twice → order D, I, then I, D.
- Store to 0x3000, data 0xBEEF, byte_enable 2'b01 → pmem_write = 1, pmem_wdata = 0xBEEF, pmem_byte_enable = 2'b01, pmem_read = 0, data_response set after resp, mem_rdata unchanged.
- Fetch 0x0050 in flight; instruction_address changes to 0x0100 before pmem_resp → response stays low, stale word discarded, new pmem_read to 0x0100 issued.
- Fetch held (instruction_response = 1) while a load stalls 5 cycles → no second pmem_read to the same address; advance occurs only after data_response.
- rst_n low during DACCESS → pmem_write/pmem_read drop asynchronously, all responses 0, state IDLE after release.

Source files
------------

// File: rtl/pipe_mem_arbiter.sv
// Purpose: merges the CPU fetch port and MEM-stage data port onto one shared memory port.
// Latency: request seen in IDLE -> strobe next cycle; response flag one cycle after pmem_resp (2 cycles minimum).
// Backpressure: requests stay high until their held response is consumed by advance; one access in flight at a time.
// Optional: define ARB_ROUND_ROBIN_EN to alternate contested grants instead of fixed DATA_FIRST priority.
module pipe_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              instruction_request,
  input  logic [ADDR_W-1:0] instruction_address,
  output logic [DATA_W-1:0] instr,
  output logic              instruction_response,
  input  logic              data_request,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data,
  input  logic [1:0]        mem_byte_enable,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              data_response,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic [1:0]        pmem_byte_enable,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IFETCH  = 2'd1,
    DACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          be_q, be_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   iaddr_q, iaddr_d;
  logic                ivalid_q, ivalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                dvalid_q, dvalid_d;

  logic dcand, icand, prefer_data, grant_data, grant_instr;
  logic ifetch_done, dacc_done;

  // A held word only answers the PC it was fetched for; a redirected PC sees no response.
  assign instruction_response = ivalid_q & (iaddr_q == instruction_address);
  assign data_response        = dvalid_q;
  assign instr                = instr_q;
  assign mem_rdata            = rdata_q;

  assign pmem_address     = addr_q;
  assign pmem_wdata       = wdata_q;
  assign pmem_byte_enable = be_q;
  assign pmem_read        = (state_q == IFETCH) | ((state_q == DACCESS) & ~we_q);
  assign pmem_write       = (state_q == DACCESS) & we_q;

  // A port competes only while it has no response already being held for it.
  assign dcand = data_request & ~dvalid_q;
  assign icand = instruction_request & ~instruction_response;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;   // 1 = data won the last contested grant
  logic unused_data_first;
  assign unused_data_first = DATA_FIRST;
  assign prefer_data       = ~last_grant_q;

  // Only contested grants move the pointer, so uncontested traffic does not skew fairness.
  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == IDLE) && dcand && icand) last_grant_d = grant_data;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b0;
    else        last_grant_q <= last_grant_d;
  end
`else
  assign prefer_data = DATA_FIRST;
`endif

  assign grant_data  = dcand & (~icand | prefer_data);
  assign grant_instr = icand & ~grant_data;

  // Next-state logic: arbitration in IDLE, completion handling, and response hold/clear rules.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    we_d        = we_q;
    instr_d     = instr_q;
    iaddr_d     = iaddr_q;
    ivalid_d    = ivalid_q;
    rdata_d     = rdata_q;
    dvalid_d    = dvalid_q;
    ifetch_done = 1'b0;
    dacc_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d = DACCESS;
          addr_d  = mem_address;
          wdata_d = write_data;
          we_d    = write_enable;
          be_d    = write_enable ? mem_byte_enable : 2'b11;
        end else if (grant_instr) begin
          state_d = IFETCH;
          addr_d  = instruction_address;
          wdata_d = '0;
          we_d    = 1'b0;
          be_d    = 2'b11;
        end
      end
      IFETCH: begin
        if (pmem_resp) begin
          state_d     = IDLE;
          ifetch_done = 1'b1;
        end
      end
      DACCESS: begin
        if (pmem_resp) begin
          state_d   = IDLE;
          dacc_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A completing fetch always lands; advance or a PC redirect only clears an older held word.
    if (ifetch_done) begin
      ivalid_d = 1'b1;
      iaddr_d  = addr_q;
      instr_d  = pmem_rdata;
    end else if (advance || (ivalid_q && (iaddr_q != instruction_address))) begin
      ivalid_d = 1'b0;
    end

    // Stores complete without touching the load-data register.
    if (dacc_done) begin
      dvalid_d = 1'b1;
      if (!we_q) rdata_d = pmem_rdata;
    end else if (advance || !data_request) begin
      dvalid_d = 1'b0;
    end
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      instr_q  <= '0;
      iaddr_q  <= '0;
      ivalid_q <= 1'b0;
      rdata_q  <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      instr_q  <= instr_d;
      iaddr_q  <= iaddr_d;
      ivalid_q <= ivalid_d;
      rdata_q  <= rdata_d;
      dvalid_q <= dvalid_d;
    end
  end

endmodule
